// File: rtl/channel_readout.sv
// channel_readout: readout controller for a bank of per-channel impulse counters.
// Opens an integration window, freezes the counters, snapshots every channel,
// clears the counters, and streams one frame of bytes per window over valid/ready.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   run         level; high = acquire frames back to back
//   ch_data     flattened counts, channel k at [k*CNT_W +: CNT_W]
//   ch_ovf      per-channel overflow flags
//   cnt_freeze  counter hold (1 = not counting)
//   cnt_clear   counter clear
//   tx_data     frame byte
//   tx_valid    tx_data valid
//   tx_ready    consumer accepts on tx_valid & tx_ready
//   busy        high whenever not IDLE
//   frame_done  one-cycle pulse after the last byte of a frame is accepted
//
// Frame layout: A5, frame index, then per channel {ovf,3'b000,data[11:8]}, data[7:0].
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | counters frozen, waiting for run
// CLEAR     | counters held in clear for CLR_LEN cycles
// INTEGRATE | counters running for WINDOW cycles
// FREEZE    | counters held for SETTLE cycles; snapshot taken on the last one
// SEND      | frame bytes streamed out over valid/ready
// WRAP      | frame finished; run decides between CLEAR and IDLE

module channel_readout #(
    parameter int N_CH    = 16,
    parameter int CNT_W   = 12,
    parameter int WINDOW  = 4096,
    parameter int SETTLE  = 2,
    parameter int CLR_LEN = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [N_CH*CNT_W-1:0] ch_data,
    input  logic [N_CH-1:0]       ch_ovf,
    output logic                  cnt_freeze,
    output logic                  cnt_clear,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int FRAME_LEN = 2 + 2 * N_CH;
    localparam int MAX_A     = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int MAX_LEN   = (MAX_A > CLR_LEN) ? MAX_A : CLR_LEN;
    localparam int TMR_W     = $clog2(MAX_LEN);
    localparam int BI_W      = $clog2(FRAME_LEN);
    localparam int CH_W      = BI_W - 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, INTEGRATE, FREEZE, SEND, WRAP
    } state_t;

    state_t                  state, state_next;
    logic [TMR_W-1:0]        timer;
    logic [BI_W-1:0]         byte_idx;
    logic [7:0]              frame_idx;
    logic [N_CH*CNT_W-1:0]   shadow_data;
    logic [N_CH-1:0]         shadow_ovf;

    logic                    timer_done;
    logic                    accept;
    logic                    last_byte;

    assign timer_done = (timer == '0);
    assign accept     = tx_valid & tx_ready;
    assign last_byte  = (byte_idx == BI_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (run) state_next = CLEAR;
            CLEAR:     if (timer_done) state_next = INTEGRATE;
            INTEGRATE: if (timer_done) state_next = FREEZE;
            FREEZE:    if (timer_done) state_next = SEND;
            SEND:      if (accept && last_byte) state_next = WRAP;
            WRAP:      state_next = run ? CLEAR : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Byte to present next: the first byte when nothing is on the bus yet,
    // otherwise the one after the byte currently being accepted.
    logic [BI_W-1:0]  sel;
    logic [BI_W-1:0]  pos;
    logic [CH_W-1:0]  ch_sel;
    logic [CNT_W-1:0] sel_data;
    logic             sel_ovf;
    logic [CNT_W-1:0] sat;
    logic [7:0]       byte_next;

    always_comb begin
        sel       = tx_valid ? byte_idx + BI_W'(1) : byte_idx;
        pos       = sel - BI_W'(2);
        ch_sel    = pos[BI_W-1:1];
        sel_data  = '0;
        sel_ovf   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_sel == CH_W'(k)) begin
                sel_data = shadow_data[k*CNT_W +: CNT_W];
                sel_ovf  = shadow_ovf[k];
            end
        end
        sat       = sel_ovf ? '1 : sel_data;
        byte_next = 8'h00;
        if (sel == BI_W'(0))      byte_next = 8'hA5;
        else if (sel == BI_W'(1)) byte_next = frame_idx;
        else if (!pos[0])         byte_next = {sel_ovf, 3'b000, sat[11:8]};
        else                      byte_next = sat[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_freeze  <= 1'b1;
            cnt_clear   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            timer       <= '0;
            byte_idx    <= '0;
            frame_idx   <= 8'h00;
            shadow_data <= '0;
            shadow_ovf  <= '0;
        end else begin
            // Control outputs follow the state being entered so they line up with it.
            cnt_freeze <= (state_next != INTEGRATE);
            cnt_clear  <= (state_next == CLEAR);
            busy       <= (state_next != IDLE);
            frame_done <= 1'b0;

            if (state_next != state) begin
                case (state_next)
                    CLEAR:     timer <= TMR_W'(CLR_LEN - 1);
                    INTEGRATE: timer <= TMR_W'(WINDOW - 1);
                    FREEZE:    timer <= TMR_W'(SETTLE - 1);
                    default:   timer <= '0;
                endcase
            end else if (!timer_done) begin
                timer <= timer - TMR_W'(1);
            end

            if (state == FREEZE && timer_done) begin
                shadow_data <= ch_data;
                shadow_ovf  <= ch_ovf;
                byte_idx    <= '0;
            end

            if (state == SEND) begin
                if (!tx_valid) begin
                    tx_valid <= 1'b1;
                    tx_data  <= byte_next;
                end else if (tx_ready) begin
                    if (last_byte) begin
                        tx_valid   <= 1'b0;
                        frame_done <= 1'b1;
                        frame_idx  <= frame_idx + 8'd1;
                        byte_idx   <= '0;
                    end else begin
                        byte_idx <= byte_idx + BI_W'(1);
                        tx_data  <= byte_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_channel_readout.sv
// Directed bench for channel_readout with N_CH=4, WINDOW=16, SETTLE=2, CLR_LEN=2.
module tb_channel_readout;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 12;
    localparam int WINDOW  = 16;
    localparam int SETTLE  = 2;
    localparam int CLR_LEN = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  run = 1'b0;
    logic [N_CH*CNT_W-1:0] ch_data = '0;
    logic [N_CH-1:0]       ch_ovf = '0;
    logic                  cnt_freeze;
    logic                  cnt_clear;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready = 1'b0;
    logic                  busy;
    logic                  frame_done;

    channel_readout #(
        .N_CH(N_CH), .CNT_W(CNT_W), .WINDOW(WINDOW), .SETTLE(SETTLE), .CLR_LEN(CLR_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ch_data(ch_data), .ch_ovf(ch_ovf),
        .cnt_freeze(cnt_freeze), .cnt_clear(cnt_clear), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [47:0] data;
        logic [3:0]  ovf;
        int          mode;
        int          drop_at;
        logic [79:0] exp;
    } vec_t;

    vec_t vecs [4];

    logic [7:0] got [16];
    int got_n, clr_cnt, frz_low, done_cnt, stab_err, ovl_err;

    // Starts a frame from IDLE, drops run after drop_at bytes, and records the
    // accepted bytes plus per-frame control statistics.
    task automatic collect_frame(input int mode, input int drop_at);
        bit         seen;
        int         post;
        bit         stalled;
        logic [7:0] pdata;
        got_n = 0; clr_cnt = 0; frz_low = 0; done_cnt = 0; stab_err = 0; ovl_err = 0;
        seen = 0; post = 0; stalled = 0; pdata = 8'h00;
        run = 1'b1;
        for (int cyc = 0; cyc < 600 && post < 3; cyc++) begin
            @(negedge clk);
            if (stalled && (!tx_valid || tx_data != pdata)) stab_err++;
            if (cnt_clear) clr_cnt++;
            if (!cnt_freeze) frz_low++;
            if (frame_done) done_cnt++;
            if (frame_done && tx_valid) ovl_err++;
            if (seen) post++;
            if (frame_done) seen = 1;
            tx_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
            if (tx_valid && tx_ready) begin
                if (got_n < 16) got[got_n[3:0]] = tx_data;
                got_n++;
                stalled = 0;
                if (got_n == drop_at) run = 1'b0;
            end else begin
                stalled = tx_valid;
                pdata   = tx_data;
            end
        end
        run = 1'b0;
    endtask

    initial begin
        int idle_clr;
        int frames, pos, integ, clr_seen, clr_err, idx_err;
        bit prev_frz, fin;
        logic [7:0] last_idx;

        vecs[0] = '{48'h003_0FF_100_ABC, 4'b0000, 0, 1, 80'hA5_00_0A_BC_01_00_00_FF_00_03};
        vecs[1] = '{48'h003_005_100_ABC, 4'b0100, 0, 1, 80'hA5_01_0A_BC_01_00_8F_FF_00_03};
        vecs[2] = '{48'h003_0FF_100_ABC, 4'b0000, 1, 1, 80'hA5_02_0A_BC_01_00_00_FF_00_03};
        vecs[3] = '{48'hFFF_800_07F_000, 4'b1001, 0, 5, 80'hA5_03_8F_FF_00_7F_08_00_8F_FF};

        #12;
        check("rst_freeze", cnt_freeze, 1);
        check("rst_clear", cnt_clear, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            ch_data = vecs[i].data;
            ch_ovf  = vecs[i].ovf;
            collect_frame(vecs[i].mode, vecs[i].drop_at);
            check($sformatf("v%0d_byte_count", i), got_n, 10);
            for (int b = 0; b < 10; b++)
                check($sformatf("v%0d_byte%0d", i, b), got[b[3:0]], vecs[i].exp[79-8*b -: 8]);
            check($sformatf("v%0d_clear_cycles", i), clr_cnt, CLR_LEN);
            check($sformatf("v%0d_window_cycles", i), frz_low, WINDOW);
            check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
            check($sformatf("v%0d_stall_stable", i), stab_err, 0);
            check($sformatf("v%0d_done_valid_overlap", i), ovl_err, 0);
            check($sformatf("v%0d_idle_busy", i), busy, 0);
            check($sformatf("v%0d_idle_freeze", i), cnt_freeze, 1);
            idle_clr = 0;
            repeat (30) begin
                @(negedge clk);
                if (cnt_clear || busy) idle_clr++;
            end
            check($sformatf("v%0d_idle_quiet", i), idle_clr, 0);
        end

        // Reset while a byte is stalled on the bus.
        @(negedge clk);
        tx_ready = 1'b0;
        ch_data  = vecs[0].data;
        ch_ovf   = 4'b0000;
        run      = 1'b1;
        for (int c = 0; c < 200 && !tx_valid; c++) @(negedge clk);
        check("rst_mid_pre_valid", tx_valid, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("rst_mid_valid", tx_valid, 0);
        check("rst_mid_freeze", cnt_freeze, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_data", tx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        collect_frame(0, 1);
        check("rst_restart_count", got_n, 10);
        check("rst_restart_hdr", got[0], 8'hA5);
        check("rst_restart_idx", got[1], 8'h00);
        check("rst_restart_clear", clr_cnt, CLR_LEN);

        // 257 back-to-back frames from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_ready = 1'b1;
        run      = 1'b1;
        frames = 0; pos = 0; integ = 0; clr_seen = 0; clr_err = 0; idx_err = 0;
        prev_frz = 1'b1; fin = 1'b0; last_idx = 8'hEE;
        for (int c = 0; c < 20000 && !fin; c++) begin
            @(negedge clk);
            if (cnt_clear) clr_seen++;
            if (!cnt_freeze && prev_frz) begin
                if (clr_seen != CLR_LEN) clr_err++;
                clr_seen = 0;
                integ++;
            end
            prev_frz = cnt_freeze;
            if (tx_valid) begin
                if (pos == 0 && tx_data != 8'hA5) idx_err++;
                if (pos == 1) begin
                    last_idx = tx_data;
                    if (tx_data != 8'(frames)) idx_err++;
                end
                pos++;
            end
            if (frame_done) begin
                if (pos != 10) idx_err++;
                frames++;
                pos = 0;
                if (frames == 257) begin
                    run = 1'b0;
                    fin = 1'b1;
                end
            end
        end
        repeat (3) @(negedge clk);
        check("long_frames", frames, 257);
        check("long_integrates", integ, 257);
        check("long_clear_before_integrate", clr_err, 0);
        check("long_index_sequence", idx_err, 0);
        check("long_last_index", last_idx, 8'h00);
        check("long_end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/channel_readout.md
Name: channel_readout

Overview:
Readout controller for the bank of per-channel impulse counters (12-bit count plus overflow flag per channel).
- Sequences integration windows, freezes and snapshots every channel, then clears the counters.
- Streams each window's spectrogram frame as bytes over a valid/ready interface toward the chip output pins.
- It is the reader/consumer side of the counters: it drives their enable (freeze) and reset (clear) inputs and consumes their data/ovf outputs.

Parameters:
N_CH, 16, number of counter channels read per frame (1..255)
CNT_W, 12, counter data width per channel (fixed 12 for byte packing)
WINDOW, 4096, integration window length in clk cycles (>=2)
SETTLE, 2, clk cycles between freeze assertion and snapshot (>=1)
CLR_LEN, 2, clk cycles cnt_clear is held high (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
run  input  1  level; high = acquire frames continuously
ch_data  input  N_CH*CNT_W  flattened counts; channel k at bits [k*12+11:k*12]
ch_ovf  input  N_CH  per-channel overflow flags
cnt_freeze  output  1  to counter enable; 1 = counters hold (no counting)
cnt_clear  output  1  to counter reset; 1 = counters cleared
tx_data  output  8  frame byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  consumer accepts byte when tx_valid&tx_ready at rising edge
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse after last byte of a frame accepted

Behaviour:
- Reset values: cnt_freeze=1, cnt_clear=0, tx_valid=0, tx_data=0, busy=0, frame_done=0, frame index=0, state IDLE.
- All outputs are registered.
- FSM states: IDLE, CLEAR, INTEGRATE, FREEZE, SEND, WRAP.
- IDLE: freeze=1. run=1 -> CLEAR.
- CLEAR: cnt_clear=1, freeze=1 for exactly CLR_LEN cycles -> INTEGRATE.
- INTEGRATE: freeze=0, cnt_clear=0 for exactly WINDOW cycles, counted by an internal window counter -> FREEZE.
- FREEZE: freeze=1 for SETTLE cycles.
  - On the last cycle, snapshot all ch_data/ch_ovf into shadow registers -> SEND.
- SEND: emit frame bytes in order:
  - Byte 0: 0xA5 header.
  - Byte 1: frame index (8-bit, wraps 255->0).
  - Then for k=0..N_CH-1: hi = {ovf_k,3'b000,data_k[11:8]}, lo = data_k[7:0].
  - Frame length = 2+2*N_CH bytes.
  - Saturation: if ovf_k=1, data_k is sent as 12'hFFF regardless of snapshot value.
- Handshake (SEND):
  - tx_valid rises the cycle after SEND entry.
  - tx_data and tx_valid are held stable while tx_valid&!tx_ready.
  - On an accept, the next byte is presented in the following cycle (tx_valid may stay high back-to-back).
  - After the last byte is accepted: tx_valid=0, frame_done pulses 1 cycle, frame index increments -> WRAP.
- WRAP: run=1 -> CLEAR; run=0 -> IDLE.
- run is sampled only in IDLE and WRAP. Deasserting run mid-frame completes the current frame.
- Counters are frozen throughout FREEZE/SEND/CLEAR, so impulses arriving then are dropped by design.
- tx_ready stuck low stalls SEND indefinitely with freeze=1. No timeout.
- rst_n low at any time: immediate return to reset values. Any partial frame is abandoned and not resumed.
- frame_done and a new tx_valid are never high in the same cycle.

Test Plan:
- N_CH=4, WINDOW=16, SETTLE=2, CLR_LEN=2; reset, run=1, tx_ready=1, ch_data={12'h003,12'h0FF,12'h100,12'hABC} (ch3..ch0) -> cnt_clear high 2 cycles, freeze low exactly 16 cycles, bytes A5,00,0A,BC,01,00,00,FF,00,03, frame_done one pulse.
- ch_ovf[2]=1 with ch_data ch2=12'h005 -> channel 2 bytes 8F,FF; other channels unaffected.
- tx_ready toggled 1-of-3 cycles -> identical byte sequence, each byte stable while stalled, no byte lost or duplicated.
- run held high for 257 frames -> frame index byte sequence 00..FF,00; cnt_clear precedes every INTEGRATE.
- run dropped during byte 5 -> frame completes all 10 bytes, then IDLE with freeze=1, busy=0, no further cnt_clear.
- rst_n pulsed low mid-SEND with tx_valid=1 -> tx_valid=0 asynchronously, freeze=1, index=0; next run restarts with CLEAR and header A5,00.
